mux_rr_nx1: RTL and testbench



---
 rtl/mux_rr_nx1_pkg.sv | 15 +
 rtl/mux_rr_nx1_arbiter.sv | 29 ++
 rtl/mux_rr_nx1.sv | 121 ++++++++++++
 tb/tb_mux_rr_nx1.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_nx1_pkg.sv
// Shared constants and helpers for the round-robin merge path.
package mux_rr_pkg;

  localparam int STAT_W = 16;
  localparam int MAX_CH = 16;

  // Modulo increment: idx+1, wrapping to 0 at n-1 (valid for any n, not only powers of 2)
  function automatic int next_idx(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/mux_rr_nx1_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found searching
// ptr, ptr+1, ... modulo NUM_CH. Returns both one-hot and binary grant.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  // Scan from the farthest candidate to the nearest so the nearest requester wins
  always_comb begin
    logic [CH_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(ptr) + k) % NUM_CH);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_nx1.sv
// N-to-1 round-robin multiplexer with valid/ready handshake and a registered
// output stage tagged with the source channel.
// Optional per-channel saturating transfer counters: define MUX_RR_STATS_EN.
module mux_rr_nx1
  import mux_rr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
`ifdef MUX_RR_STATS_EN
  input  logic [CH_W-1:0]          stat_sel,
  output logic [STAT_W-1:0]        stat_cnt,
`endif
  input  logic                     out_ready
);

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              valid_q, valid_d;

  logic [NUM_CH-1:0] grant_oh;
  logic [CH_W-1:0]   grant_idx;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic              load;
  logic              any_valid;

  // Slice the flat input bus into one word per channel
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx)
  );

  // Output stage can take a beat when empty or when its beat drains this cycle
  assign load      = ~valid_q | out_ready;
  assign any_valid = |in_valid;
  assign in_ready  = {NUM_CH{load}} & grant_oh;

  // Next state of the output register and priority pointer
  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (load) begin
      if (any_valid) begin
        data_d  = ch_data[grant_idx];
        ch_d    = grant_idx;
        valid_d = 1'b1;
        ptr_d   = CH_W'(next_idx(int'(grant_idx), NUM_CH));
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any pending beat and rewinds the pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

`ifdef MUX_RR_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_CH];
  logic [NUM_CH-1:0] stat_inc;

  // A counter advances on a transfer from its channel unless already saturated
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stat_inc
      assign stat_inc[gi] = in_ready[gi] & in_valid[gi] & ~(&stat_q[gi]);
    end
  endgenerate

  // Per-channel saturating transfer counters
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        stat_q[i] <= '0;
      end else if (stat_inc[i]) begin
        stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  assign stat_cnt = (32'(stat_sel) < NUM_CH) ? stat_q[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed self-checking bench for mux_rr_nx1 with NUM_CH=4, DATA_W=8.
// Counter checks run only when MUX_RR_STATS_EN is defined.
module tb_mux_rr_nx1;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_valid;
  logic                     out_ready;
`ifdef MUX_RR_STATS_EN
  logic [CH_W-1:0]          stat_sel;
  logic [15:0]              stat_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Per-channel payloads: ch0=0x10, ch1=0x21, ch2=0x32, ch3=0x43
  logic [DATA_W-1:0] pay [NUM_CH];

  mux_rr_nx1 #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
`ifdef MUX_RR_STATS_EN
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the registered output beat
  task automatic chk_out(input string tag, input logic v, input logic [CH_W-1:0] c,
                         input logic [DATA_W-1:0] d);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".out_ch"},    32'(out_ch),    32'(c));
    chk({tag, ".out_data"},  32'(out_data),  32'(d));
    $display("step %s: valid=%0d ch=%0d data=0x%02h", tag, out_valid, out_ch, out_data);
  endtask

  int exp_seq1 [5] = '{0, 1, 2, 3, 0};
  int exp_seq3 [3] = '{3, 0, 3};

  initial begin
    pay[0] = 8'h10; pay[1] = 8'h21; pay[2] = 8'h32; pay[3] = 8'h43;
    in_data   = {pay[3], pay[2], pay[1], pay[0]};
    in_valid  = '0;
    out_ready = 1'b1;
    reset     = 1'b1;
`ifdef MUX_RR_STATS_EN
    stat_sel  = '0;
`endif

    // Reset state
    tick();
    tick();
    chk_out("reset", 1'b0, 2'd0, 8'h00);
    #1;
    chk("reset.in_ready_idle", 32'(in_ready), 32'h0);

    // All channels valid: 0,1,2,3,0 with one in_ready bit per cycle
    reset    = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr%0d.in_ready", i), 32'(in_ready), 32'(1 << exp_seq1[i]));
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, CH_W'(exp_seq1[i]), pay[exp_seq1[i]]);
    end

    // Only ch2 valid (ptr=1): ch2 every cycle, no idle slots
    in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("solo%0d.in_ready", i), 32'(in_ready), 32'h4);
      tick();
      chk_out($sformatf("solo%0d", i), 1'b1, 2'd2, 8'h32);
    end
    // Pointer now 3: with all valid, ch3 must be offered first
    in_valid = 4'b1111;
    #1;
    chk("solo.ptr_is_3", 32'(in_ready), 32'h8);

    // No channel valid: out_valid drops, data/ch hold, pointer holds
    in_valid = 4'b0000;
    #1;
    chk("idle.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("idle", 1'b0, 2'd2, 8'h32);

    // Bring ptr to 1 via a ch0 transfer (ptr was 3, only ch0 valid)
    in_valid = 4'b0001;
    tick();
    chk_out("to_ptr1", 1'b1, 2'd0, 8'h10);

    // ch0 and ch3 valid, ptr=1: ch3, then ch0 (wrap), then ch3
    in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("wrap%0d.in_ready", i), 32'(in_ready), 32'(1 << exp_seq3[i]));
      tick();
      chk_out($sformatf("wrap%0d", i), 1'b1, CH_W'(exp_seq3[i]), pay[exp_seq3[i]]);
    end

    // Stall 3 cycles holding ch3 beat; ptr=0, ch1/ch2 waiting
    out_ready = 1'b0;
    in_valid  = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'h0);
      tick();
      chk_out($sformatf("stall%0d", i), 1'b1, 2'd3, 8'h43);
    end
    // Release: held beat drains and ch1 loads on the same edge
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("release", 1'b1, 2'd1, 8'h21);
    #1;
    chk("release2.in_ready", 32'(in_ready), 32'h4);
    tick();
    chk_out("release2", 1'b1, 2'd2, 8'h32);

    // Set ptr=2 with out_valid=1 via a ch1 transfer (ptr was 3)
    in_valid = 4'b0010;
    tick();
    chk_out("pre_reset", 1'b1, 2'd1, 8'h21);

    // Mid-stream reset: beat discarded, pointer back to 0
    reset    = 1'b1;
    in_valid = 4'b1111;
    tick();
    chk_out("mid_reset", 1'b0, 2'd0, 8'h00);
    reset = 1'b0;
    #1;
    chk("post_reset.in_ready", 32'(in_ready), 32'h1);
    tick();
    chk_out("post_reset", 1'b1, 2'd0, 8'h10);

`ifdef MUX_RR_STATS_EN
    // Counters: saturate ch1 with 70000 transfers, others stay 0
    reset    = 1'b1;
    in_valid = 4'b0000;
    tick();
    reset    = 1'b0;
    in_valid = 4'b0010;
    stat_sel = 2'd1;
    for (int i = 0; i < 3; i++) tick();
    chk("stat.ch1_small", 32'(stat_cnt), 32'd3);
    for (int i = 0; i < 69997; i++) tick();
    in_valid = 4'b0000;
    tick();
    for (int s = 0; s < NUM_CH; s++) begin
      stat_sel = CH_W'(s);
      #1;
      chk($sformatf("stat.sat_ch%0d", s), 32'(stat_cnt), (s == 1) ? 32'hFFFF : 32'h0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int s = 0; s < NUM_CH; s++) begin
      stat_sel = CH_W'(s);
      #1;
      chk($sformatf("stat.clr_ch%0d", s), 32'(stat_cnt), 32'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
